align_shift_arbiter: RTL and testbench

ALIGN_SHIFT_ARBITER -- requirements
Module: align_shift_arbiter

---
 rtl/align_shift_arbiter.sv | 102 ++++++++++
 tb/tb_align_shift_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/align_shift_arbiter.sv
// Two-requester round-robin arbiter sharing one right-shift aligner with a single-entry result register.
// Optional sticky output enabled by defining STICKY_EN.
module align_shift_arbiter #(
  parameter int unsigned MANT_W = 5,
  parameter int unsigned EXP_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [MANT_W-1:0] req0_mant,
  input  logic [EXP_W-1:0]  req0_shamt,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [MANT_W-1:0] req1_mant,
  input  logic [EXP_W-1:0]  req1_shamt,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MANT_W-1:0] res_mant,
  output logic              res_id
`ifdef STICKY_EN
  , output logic            res_sticky
`endif
);

  logic              ptr_q, ptr_d;
  logic              res_valid_q, res_valid_d;
  logic [MANT_W-1:0] res_mant_q, res_mant_d;
  logic              res_id_q, res_id_d;
  logic              free;
  logic              gnt0, gnt1;
  logic [MANT_W-1:0] sel_mant;
  logic [EXP_W-1:0]  sel_shamt;
  logic              shamt_big;
`ifdef STICKY_EN
  logic              res_sticky_q, res_sticky_d;
`endif

  always_comb begin
    free = !res_valid_q || res_ready;
    // Contention goes to the pointer; a lone requester wins regardless of pointer.
    gnt0 = !rst && free && req0_valid && (!req1_valid || !ptr_q);
    gnt1 = !rst && free && req1_valid && (!req0_valid ||  ptr_q);
    sel_mant  = gnt1 ? req1_mant  : req0_mant;
    sel_shamt = gnt1 ? req1_shamt : req0_shamt;
    shamt_big = (32'(sel_shamt) >= MANT_W);
  end

  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_mant_d  = res_mant_q;
    res_id_d    = res_id_q;
`ifdef STICKY_EN
    res_sticky_d = res_sticky_q;
`endif
    if (gnt0 || gnt1) begin
      ptr_d       = gnt0;
      res_valid_d = 1'b1;
      res_id_d    = gnt1;
      res_mant_d  = shamt_big ? '0 : (sel_mant >> sel_shamt);
`ifdef STICKY_EN
      res_sticky_d = 1'b0;
      for (int unsigned i = 0; i < MANT_W; i++) begin
        if (i < 32'(sel_shamt)) res_sticky_d = res_sticky_d | sel_mant[i];
      end
`endif
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_mant_q  <= '0;
      res_id_q    <= 1'b0;
`ifdef STICKY_EN
      res_sticky_q <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_mant_q  <= res_mant_d;
      res_id_q    <= res_id_d;
`ifdef STICKY_EN
      res_sticky_q <= res_sticky_d;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign res_valid  = res_valid_q;
  assign res_mant   = res_mant_q;
  assign res_id     = res_id_q;
`ifdef STICKY_EN
  assign res_sticky = res_sticky_q;
`endif

endmodule

// File: tb/tb_align_shift_arbiter.sv
// Randomized self-checking bench for align_shift_arbiter against a transaction-level reference model.
module tb_align_shift_arbiter;
  localparam int unsigned MANT_W = 5;
  localparam int unsigned EXP_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [MANT_W-1:0] req0_mant, req1_mant;
  logic [EXP_W-1:0]  req0_shamt, req1_shamt;
  logic              req0_ready, req1_ready;
  logic              res_valid, res_ready, res_id;
  logic [MANT_W-1:0] res_mant;
`ifdef STICKY_EN
  logic              res_sticky;
`endif

  align_shift_arbiter #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mant(req0_mant), .req0_shamt(req0_shamt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mant(req1_mant), .req1_shamt(req1_shamt), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_mant(res_mant), .res_id(res_id)
`ifdef STICKY_EN
    , .res_sticky(res_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one result slot plus the "whose turn on contention" requester.
  int m_valid, m_mant, m_id, m_sticky, m_turn;
  int e_g0, e_g1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_shift(input int m, input int s);
    if (s >= MANT_W) return 0;
    return m / (1 << s);
  endfunction

  function automatic int ref_sticky(input int m, input int s);
    if (s >= MANT_W) return (m != 0) ? 1 : 0;
    return ((m % (1 << s)) != 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mant = 0; m_id = 0; m_sticky = 0; m_turn = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, res_valid, m_valid);
    check_eq({tag, "_mant"}, res_mant, m_mant);
    check_eq({tag, "_id"}, res_id, m_id);
`ifdef STICKY_EN
    check_eq({tag, "_sticky"}, res_sticky, m_sticky);
`endif
  endtask

  // One clock cycle: drive at negedge, check ready, advance model at posedge, check result.
  task automatic step(input logic v0, input int mt0, input int s0,
                      input logic v1, input int mt1, input int s1, input logic rr);
    int free, src_m, src_s;
    @(negedge clk);
    req0_valid = v0; req0_mant = MANT_W'(mt0); req0_shamt = EXP_W'(s0);
    req1_valid = v1; req1_mant = MANT_W'(mt1); req1_shamt = EXP_W'(s1);
    res_ready = rr;
    #1;
    free = (m_valid == 0 || rr) ? 1 : 0;
    e_g0 = 0; e_g1 = 0;
    if (free != 0) begin
      if (v0 && v1) begin
        if (m_turn == 0) e_g0 = 1; else e_g1 = 1;
      end else if (v0) e_g0 = 1;
      else if (v1) e_g1 = 1;
    end
    check_eq("ready0", req0_ready, e_g0);
    check_eq("ready1", req1_ready, e_g1);
    @(posedge clk);
    if (e_g0 != 0 || e_g1 != 0) begin
      src_m = (e_g1 != 0) ? mt1 : mt0;
      src_s = (e_g1 != 0) ? s1 : s0;
      m_valid = 1;
      m_id = e_g1;
      m_mant = ref_shift(src_m, src_s);
      m_sticky = ref_sticky(src_m, src_s);
      m_turn = (e_g1 != 0) ? 0 : 1;
    end else if (rr) begin
      m_valid = 0;
    end
    #1;
    check_outputs("res");
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_mant = '0; req1_mant = '0;
    req0_shamt = '0; req1_shamt = '0; res_ready = 0;
  endtask

  // Asynchronous reset asserted mid-cycle, released at a negedge.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs("rst_async");
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    #1;
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    int sa, sb;
    idle_inputs();
    rst = 1;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Single request; first grant on the first edge after reset release.
    step(1, 5'b10110, 2, 0, 0, 0, 1);
    check_eq("basic_mant", res_mant, 5'b00101);
    check_eq("basic_id", res_id, 0);

    // Contention: alternating grants, one result per cycle.
    for (int i = 0; i < 4; i++) step(1, i + 1, 0, 1, i + 17, 0, 1);

    // Large shifts, including upper shamt bits set, and zero shift.
    step(1, 5'b11111, 8, 0, 0, 0, 1);
    check_eq("big8_mant", res_mant, 0);
    step(0, 0, 0, 1, 5'b11111, 33, 1);
    check_eq("big33_mant", res_mant, 0);
    step(1, 5'b10001, 0, 0, 0, 0, 1);
    check_eq("zero_mant", res_mant, 5'b10001);

    // Back-pressure: result held, no grants; then drain and reload together.
    step(1, 5'b01101, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, i, 0, 1, 5'b11100, 1, 0);
    step(0, 0, 0, 1, 5'b11100, 1, 1);
    check_eq("reload_valid", res_valid, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check_eq("drain_valid", res_valid, 0);

    // Pending result and pointer at 1 discarded by reset; requester 0 wins first afterwards.
    step(1, 5'b10101, 0, 0, 0, 0, 0);
    pulse_reset();
    step(1, 3, 0, 1, 9, 0, 1);
    check_eq("post_rst_id", res_id, 0);

    for (int i = 0; i < 600; i++) begin
      sa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, MANT_W));
      sb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, MANT_W));
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), sa,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), sb,
           $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
